// File: rtl/alu_pipe_unit.sv
// alu_pipe_unit: two-stage valid/ready pipelined ALU with carry/zero flags
// and an accumulate mode.
//   S1 registers the operand beat (a, b, opcode).
//   S2 computes from S1 and registers result, carry and zero.
// Optional build macro: ALU_SATURATE_EN -- ADD/ACC clamp to all-ones on
// overflow and SUB clamps to zero on borrow (carry still reports the event).
module alu_pipe_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic [2:0]       io_opcode,
  input  logic             io_acc_clear,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out,
  output logic             io_carry,
  output logic             io_zero,
  output logic [WIDTH-1:0] io_acc
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_PASSA = 3'b010,
    OP_PASSB = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_XOR   = 3'b110,
    OP_ACC   = 3'b111
  } op_e;

  // S1 operand register
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  op_e              s1_op_q;

  // S2 result register
  logic             s2_valid_q;
  logic [WIDTH-1:0] out_q;
  logic             carry_q;
  logic             zero_q;

  logic [WIDTH-1:0] acc_q;

  // Combinational datapath
  logic             s2_load;
  logic             in_accept;
  logic [WIDTH-1:0] acc_opnd;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;

  // S2 accepts a beat when it is empty or its current beat is being consumed.
  assign s2_load     = s1_valid_q && (!s2_valid_q || io_out_ready);
  assign io_in_ready = !s1_valid_q || s2_load;
  assign in_accept   = io_in_valid && io_in_ready;

  // A clear in the same cycle as an ACC load makes that beat see a zero accumulator.
  assign acc_opnd = io_acc_clear ? '0 : acc_q;

  // ALU: unsigned WIDTH+1 arithmetic, carry/borrow in the top bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sum_w   = '0;
    res_d   = '0;
    carry_d = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        sum_w   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        carry_d = sum_w[WIDTH];
        res_d   = sum_w[WIDTH-1:0];
`ifdef ALU_SATURATE_EN
        if (carry_d) res_d = '1;
`endif
      end
      OP_SUB: begin
        // The top bit of the extended difference is set exactly when a < b.
        sum_w   = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        carry_d = sum_w[WIDTH];
        res_d   = sum_w[WIDTH-1:0];
`ifdef ALU_SATURATE_EN
        if (carry_d) res_d = '0;
`endif
      end
      OP_PASSA: res_d = s1_a_q;
      OP_PASSB: res_d = s1_b_q;
      OP_AND:   res_d = s1_a_q & s1_b_q;
      OP_OR:    res_d = s1_a_q | s1_b_q;
      OP_XOR:   res_d = s1_a_q ^ s1_b_q;
      OP_ACC: begin
        sum_w   = {1'b0, acc_opnd} + {1'b0, s1_a_q};
        carry_d = sum_w[WIDTH];
        res_d   = sum_w[WIDTH-1:0];
`ifdef ALU_SATURATE_EN
        if (carry_d) res_d = '1;
`endif
      end
      default: res_d = '0;
    endcase
  end

  // S1: capture an accepted beat, or empty once its beat moves into S2.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_ADD;
    end else if (in_accept) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= io_a;
      s1_b_q     <= io_b;
      s1_op_q    <= op_e'(io_opcode);
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  // S2: register result and flags; hold them while the consumer stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= 1'b1;
      out_q      <= res_d;
      carry_q    <= carry_d;
      zero_q     <= (res_d == '0);
    end else if (io_out_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

  // Accumulator: takes the (clamped) result of an ACC beat entering S2, else honours clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
    end else if (s2_load && (s1_op_q == OP_ACC)) begin
      acc_q <= res_d;
    end else if (io_acc_clear) begin
      acc_q <= '0;
    end
  end

  assign io_out_valid = s2_valid_q;
  assign io_out       = out_q;
  assign io_carry     = carry_q;
  assign io_zero      = zero_q;
  assign io_acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Self-checking bench for alu_pipe_unit (WIDTH=8) with a result scoreboard.
module tb_alu_pipe_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [7:0] io_a;
  logic [7:0] io_b;
  logic [2:0] io_opcode;
  logic       io_acc_clear;
  logic       io_out_valid;
  logic       io_out_ready;
  logic [7:0] io_out;
  logic       io_carry;
  logic       io_zero;
  logic [7:0] io_acc;

  alu_pipe_unit #(.WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_a        (io_a),
    .io_b        (io_b),
    .io_opcode   (io_opcode),
    .io_acc_clear(io_acc_clear),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out      (io_out),
    .io_carry    (io_carry),
    .io_zero     (io_zero),
    .io_acc      (io_acc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] out;
    logic       carry;
    logic       zero;
    bit         lat;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [7:0] model_acc = 8'd0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference ALU, written independently of the RTL using integer arithmetic.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] op, input logic [7:0] acc);
    exp_t e;
    int   s;
    e.carry = 1'b0;
    e.out   = 8'd0;
    case (op)
      3'd0, 3'd7: begin
        s       = (op == 3'd0) ? int'(a) + int'(b) : int'(acc) + int'(a);
        e.carry = (s > 255);
        e.out   = 8'(s % 256);
`ifdef ALU_SATURATE_EN
        if (e.carry) e.out = 8'd255;
`endif
      end
      3'd1: begin
        s       = int'(a) - int'(b);
        e.carry = (s < 0);
        e.out   = 8'((s + 256) % 256);
`ifdef ALU_SATURATE_EN
        if (e.carry) e.out = 8'd0;
`endif
      end
      3'd2: e.out = a;
      3'd3: e.out = b;
      3'd4: e.out = a & b;
      3'd5: e.out = a | b;
      default: e.out = a ^ b;
    endcase
    e.zero = (e.out == 8'd0);
    e.lat  = 1'b0;
    e.cyc  = 0;
    return e;
  endfunction

  // Offer one beat starting at a falling edge; push its expectation on acceptance.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input bit lat);
    exp_t e;
    int   waits;
    io_a        = a;
    io_b        = b;
    io_opcode   = op;
    io_in_valid = 1'b1;
    #1;
    waits = 0;
    while (!io_in_ready && waits < 50) begin
      @(negedge clock);
      #1;
      waits++;
    end
    if (!io_in_ready) begin
      check("in_ready_timeout", io_in_ready, 1);
    end else begin
      if (lat) check("no_stall", waits, 0);
      e     = model(a, b, op, model_acc);
      e.lat = lat;
      e.cyc = cyc;
      if (op == 3'd7) model_acc = e.out;
      sb_q.push_back(e);
    end
    @(posedge clock);
    @(negedge clock);
    io_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", sb_q.size(), 0);
    @(negedge clock);
  endtask

  // Result monitor: samples well after the falling edge, away from the active edge.
  always begin
    @(negedge clock);
    #2;
    if (!reset && io_out_valid && io_out_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", io_out_valid, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("out",   io_out,   mon_e.out);
        check("carry", io_carry, mon_e.carry);
        check("zero",  io_zero,  mon_e.zero);
        if (mon_e.lat) check("latency", cyc - mon_e.cyc, 2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_a         = 8'd0;
    io_b         = 8'd0;
    io_opcode    = 3'd0;
    io_acc_clear = 1'b0;
    io_out_ready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_out_valid", io_out_valid, 0);
    check("rst_out",       io_out,       0);
    check("rst_carry",     io_carry,     0);
    check("rst_zero",      io_zero,      0);
    check("rst_acc",       io_acc,       0);
    check("rst_in_ready",  io_in_ready,  1);
    @(negedge clock);

    // ADD wrap / saturate, with latency check
    send(8'd200, 8'd100, 3'd0, 1'b1);
    // SUB borrow and zero flag
    send(8'd5, 8'd7, 3'd1, 1'b1);
    send(8'd9, 8'd9, 3'd1, 1'b1);
    drain();

    // Backpressure: two beats fill the pipe, the third is held off.
    io_out_ready = 1'b0;
    send(8'd1, 8'd2, 3'd0, 1'b0);
    send(8'd10, 8'd20, 3'd0, 1'b0);
    io_a        = 8'd100;
    io_b        = 8'd50;
    io_opcode   = 3'd0;
    io_in_valid = 1'b1;
    #1;
    check("bp_in_ready_low", io_in_ready, 0);
    repeat (3) begin
      @(negedge clock);
      #1;
      check("bp_hold_out",   io_out,      3);
      check("bp_hold_ready", io_in_ready, 0);
    end
    @(negedge clock);
    io_out_ready = 1'b1;
    #1;
    check("bp_release_ready", io_in_ready, 1);
    mon_e     = model(8'd100, 8'd50, 3'd0, model_acc);
    mon_e.lat = 1'b0;
    sb_q.push_back(mon_e);
    @(posedge clock);
    @(negedge clock);
    io_in_valid = 1'b0;
    drain();

    // Accumulate after an idle clear
    io_acc_clear = 1'b1;
    @(negedge clock);
    io_acc_clear = 1'b0;
    model_acc    = 8'd0;
    send(8'd10, 8'd0, 3'd7, 1'b1);
    send(8'd20, 8'd0, 3'd7, 1'b1);
    send(8'd30, 8'd0, 3'd7, 1'b1);
    drain();
    check("acc_sum", io_acc, 60);

    // ACC beat with clear asserted in its S2-load cycle
    model_acc = 8'd0;
    send(8'd5, 8'd0, 3'd7, 1'b1);
    io_acc_clear = 1'b1;
    @(negedge clock);
    io_acc_clear = 1'b0;
    drain();
    check("acc_clear_coincide", io_acc, 5);

    // Logic and pass ops back to back
    send(8'hF0, 8'h3C, 3'd4, 1'b1);
    send(8'hF0, 8'h3C, 3'd5, 1'b1);
    send(8'hF0, 8'h3C, 3'd6, 1'b1);
    send(8'hF0, 8'h3C, 3'd2, 1'b1);
    send(8'hF0, 8'h3C, 3'd3, 1'b1);
    drain();

    // Reset with both stages full and the consumer stalled
    io_out_ready = 1'b0;
    send(8'd3, 8'd4, 3'd0, 1'b0);
    send(8'd5, 8'd6, 3'd0, 1'b0);
    #1;
    check("full_in_ready", io_in_ready, 0);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", io_out_valid, 0);
    check("mid_rst_out",       io_out,       0);
    check("mid_rst_acc",       io_acc,       0);
    check("mid_rst_in_ready",  io_in_ready,  1);
    io_out_ready = 1'b1;
    repeat (5) begin
      @(negedge clock);
      #1;
      check("no_stale_beat", io_out_valid, 0);
    end

    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
